pudding_dac_loader: RTL and testbench
=====================================

Name: pudding_dac_loader

Overview:
- Digital control stage feeding the two 128-cell current-steering DAC arrays: produces the 128-bit cell codes and 4-bit enables consumed by the inverter-pair drivers.
- Holds a 132-bit serial daisychain (shadow) register and a 132-bit state (live) register, with transfer in either direction.
- Includes a triangle-ramp generator that drives the state register with a thermometer code for on-chip linearity sweeps.
- Sits between the pad inputs (ui_in) and the driver/DAC macros.

Parameters:
- N_CELLS, 128, DAC unit cells per array.
- N_EN, 4, enable groups per array (32 cells each).
- DIV_LOG2, 4, ramp prescaler; one ramp step every 2**DIV_LOG2 clocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- datum  in  1  serial data bit.
- shift  in  1  shift daisychain by one.
- transfer  in  1  parallel copy between chain and state.
- dir  in  1  transfer direction: 1 = chain->state, 0 = state->chain.
- ramp_en  in  1  level; 1 = ramp generator owns state.
- state_o  out  N_CELLS  live code to the state DAC (digitalL path).
- state_en_o  out  N_EN  live enables to the state DAC.
- daisy_o  out  N_CELLS  chain code to the daisychain DAC (digitalH path).
- daisy_en_o  out  N_EN  chain enables.
- sout  out  1  chain MSB (bit 131), for readback/cascade.
- ramp_level_o  out  8  current ramp level 0..128.
- busy  out  1  high while FSM is not MANUAL.

Behaviour:
- Chain layout: chain[131:128] = enables, chain[127:0] = cells; state uses the same layout. Outputs are register slices, with no combinational path from the inputs.
- Reset (rst_n=0 at a clk edge): chain = 0, state = 0, prescaler = 0, level = 0, FSM = MANUAL. All outputs read 0 in the cycle after the edge. Reset overrides everything, including mid-ramp and mid-shift.
- Shift: chain <= {chain[130:0], datum}. The first bit shifted in ends at bit 131 after 132 shifts.
- Transfer with dir=1: state <= chain.
- Transfer with dir=0: chain <= state.
- transfer has priority over shift in the same cycle; the shift is dropped.
- Effects are visible one cycle after the sampling edge (latency 1).
- FSM states: MANUAL, UP, DOWN.
- MANUAL -> UP when ramp_en=1. On entry: level = 0, prescaler = 0, state[127:0] = 0, state[131:128] = 4'hF.
- UP, on each tick (prescaler wraps to 0): level++. state[127:0] = thermometer(level), i.e. bits [level-1:0] set. When level reaches 128 -> DOWN.
- DOWN, on each tick: level--. When level reaches 0 -> UP.
- Full period = 256 ticks. Level 128 (all ones) and level 0 are each held for exactly one tick period.
- UP/DOWN -> MANUAL when ramp_en=0, at the next edge. State keeps its last ramp value; level is frozen.
- While in UP/DOWN, transfer with dir=1 is ignored. Transfer with dir=0 and shift act normally on the chain (snapshot of a live ramp code).
- ramp_en toggling 1->0->1 restarts from level 0.
- Level arithmetic is 8-bit unsigned and never leaves 0..128.
- busy = (FSM != MANUAL), registered.

Decomposition:
- Package pudding_pkg:
  - N_CELLS, N_EN, CHAIN_W = N_CELLS + N_EN.
  - Enum ramp_state_t {MANUAL, UP, DOWN}.
  - Index constants EN_LSB = 128, EN_MSB = 131.
- Sub-module pudding_therm_enc: purely combinational, 8-bit level -> 128-bit thermometer code; saturates at 128. Instantiated once.
- Top holds the chain/state registers, prescaler and FSM.

Test Plan:
- Reset: drive shift=1, datum=1 for 10 cycles, then rst_n=0 for one edge -> all outputs 0, busy=0, ramp_level_o=0.
- Serial load: shift in 132 bits, pattern 4'hA followed by 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, then pulse transfer with dir=1 -> state_en_o=4'hA, state_o equals the pattern one cycle after the pulse; sout equals chain bit 131 throughout.
- Readback and priority: state loaded, chain cleared; assert transfer with dir=0 and shift=1 in the same cycle -> chain==state (shift dropped). Then 132 shifts -> sout streams the state MSB first.
- Ramp sweep with DIV_LOG2=0: ramp_en=1 -> state_en_o=4'hF. After 128 ticks state_o is all ones; after 256 ticks it is 0; ramp_level_o is triangular with no skipped or repeated values except the endpoints.
- Ramp abort: at level 37 drop ramp_en -> FSM is MANUAL next cycle, state_o holds 37 ones. Re-raise ramp_en -> level restarts at 0.
- Ramp lockout: during UP, pulse transfer with dir=1 -> state is unchanged. Pulse transfer with dir=0 -> daisy_o snapshots the current thermometer code.

Source files
------------

// File: rtl/pudding_pkg.sv
// pudding_pkg: shared widths, chain layout and ramp FSM encoding for the DAC loader
package pudding_pkg;
  localparam int N_CELLS = 128;
  localparam int N_EN = 4;
  localparam int CHAIN_W = N_CELLS + N_EN;
  localparam int EN_LSB = 128;
  localparam int EN_MSB = 131;
  localparam logic [7:0] LEVEL_MAX = 8'd128;
  typedef enum logic [1:0] {MANUAL, UP, DOWN} ramp_state_t;
endpackage

// File: rtl/pudding_therm_enc.sv
// pudding_therm_enc: 8-bit level to thermometer code, saturating at all ones
module pudding_therm_enc
  import pudding_pkg::*;
(
  input  logic [7:0]         level,
  output logic [N_CELLS-1:0] code
);
  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    assign code[i] = level > 8'(i);
  end
endmodule

// File: rtl/pudding_dac_loader.sv
// pudding_dac_loader: daisychain/state registers and triangle ramp driving the DAC cell arrays
module pudding_dac_loader
  import pudding_pkg::*;
#(
  parameter int DIV_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               datum,
  input  logic               shift,
  input  logic               transfer,
  input  logic               dir,
  input  logic               ramp_en,
  output logic [N_CELLS-1:0] state_o,
  output logic [N_EN-1:0]    state_en_o,
  output logic [N_CELLS-1:0] daisy_o,
  output logic [N_EN-1:0]    daisy_en_o,
  output logic               sout,
  output logic [7:0]         ramp_level_o,
  output logic               busy
);
  localparam int PW = DIV_LOG2 > 0 ? DIV_LOG2 : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'((1 << DIV_LOG2) - 1);
  ramp_state_t fsm_q, fsm_d;
  logic [CHAIN_W-1:0] chain_q, chain_d, state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] level_q, level_d;
  logic busy_q, busy_d;
  logic tick;
  logic [N_CELLS-1:0] therm;
  // encoder sees the next level so the cell code lands together with it
  pudding_therm_enc u_therm (
    .level(level_d),
    .code (therm)
  );
  always_comb begin
    tick = pre_q == PRE_MAX;
    fsm_d = fsm_q;
    pre_d = pre_q;
    level_d = level_q;
    if (fsm_q == MANUAL) begin
      if (ramp_en) begin
        fsm_d = UP;
        pre_d = '0;
        level_d = '0;
      end
    end else if (!ramp_en) begin
      fsm_d = MANUAL;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        level_d = fsm_q == UP ? level_q + 8'd1 : level_q - 8'd1;
        fsm_d = level_d == LEVEL_MAX ? DOWN : level_d == 8'd0 ? UP : fsm_q;
      end
    end
    busy_d = fsm_d != MANUAL;
  end
  always_comb begin
    chain_d = transfer && !dir ? state_q : shift ? {chain_q[CHAIN_W-2:0], datum} : chain_q;
    state_d = fsm_q == MANUAL ? (ramp_en ? {{N_EN{1'b1}}, therm} : transfer && dir ? chain_q : state_q)
            : ramp_en && tick ? {{N_EN{1'b1}}, therm} : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= MANUAL;
      chain_q <= '0;
      state_q <= '0;
      pre_q <= '0;
      level_q <= '0;
      busy_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      chain_q <= chain_d;
      state_q <= state_d;
      pre_q <= pre_d;
      level_q <= level_d;
      busy_q <= busy_d;
    end
  end
  assign state_o = state_q[N_CELLS-1:0];
  assign state_en_o = state_q[EN_MSB:EN_LSB];
  assign daisy_o = chain_q[N_CELLS-1:0];
  assign daisy_en_o = chain_q[EN_MSB:EN_LSB];
  assign sout = chain_q[EN_MSB];
  assign ramp_level_o = level_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_pudding_dac_loader.sv
// tb_pudding_dac_loader: randomized scoreboard bench against a behavioural chain/ramp model
module tb_pudding_dac_loader;
  logic clk = 0, rst_n = 1, datum = 0, shift = 0, transfer = 0, dir = 0, ramp_en = 0;
  logic [127:0] state_o, daisy_o;
  logic [3:0] state_en_o, daisy_en_o;
  logic sout, busy;
  logic [7:0] ramp_level_o;
  always #5 clk = ~clk;
  pudding_dac_loader #(.DIV_LOG2(0)) dut (
    .clk(clk), .rst_n(rst_n), .datum(datum), .shift(shift), .transfer(transfer),
    .dir(dir), .ramp_en(ramp_en), .state_o(state_o), .state_en_o(state_en_o),
    .daisy_o(daisy_o), .daisy_en_o(daisy_en_o), .sout(sout),
    .ramp_level_o(ramp_level_o), .busy(busy)
  );
  typedef struct {
    logic [131:0] st;
    logic [131:0] ch;
    logic [7:0]   lvl;
    logic         bsy;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [131:0] m_ch, m_st;
  bit m_ramp = 0, known = 0;
  int m_t = 0, m_lvl = 0;
  function automatic int ramp_shape(int t);
    int m;
    m = t % 256;
    return m <= 128 ? m : 256 - m;
  endfunction
  function automatic logic [127:0] therm(int l);
    logic [127:0] ones;
    ones = '1;
    return l == 0 ? '0 : ones >> (128 - l);
  endfunction
  task automatic chk(string name, logic [131:0] act, logic [131:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state", {state_en_o, state_o}, e.st);
      chk("chain", {daisy_en_o, daisy_o}, e.ch);
      chk("sout", 132'(sout), 132'(e.ch[131]));
      chk("level", 132'(ramp_level_o), 132'(e.lvl));
      chk("busy", 132'(busy), 132'(e.bsy));
    end
  end
  task automatic cyc(bit r, bit d, bit s, bit tr, bit dr, bit re);
    logic [131:0] old_st;
    rst_n = r; datum = d; shift = s; transfer = tr; dir = dr; ramp_en = re;
    @(posedge clk);
    if (!r) begin
      known = 1; m_ch = '0; m_st = '0; m_ramp = 0; m_t = 0; m_lvl = 0;
    end else if (known) begin
      old_st = m_st;
      if (re && !m_ramp) begin
        m_ramp = 1; m_t = 0; m_lvl = 0; m_st = {4'hF, 128'b0};
      end else if (m_ramp && re) begin
        m_t++; m_lvl = ramp_shape(m_t); m_st = {4'hF, therm(m_lvl)};
      end else if (m_ramp) begin
        m_ramp = 0;
      end else if (tr && dr) begin
        m_st = m_ch;
      end
      m_ch = tr && !dr ? old_st : s ? {m_ch[130:0], d} : m_ch;
    end
    if (known) sb.push_back('{m_st, m_ch, 8'(m_lvl), m_ramp});
    #1;
  endtask
  initial begin
    logic [131:0] pat;
    bit re;
    pat = {4'hA, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF};
    repeat (10) cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    for (int i = 131; i >= 0; i--) cyc(1, pat[i], 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (132) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 132; i++) cyc(1, 1'($urandom), 1, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      cyc(1, 1'($urandom), 1'($urandom), $urandom_range(7) == 0, 1'($urandom), 0);
    for (int i = 0; i < 20; i++) cyc(1, 1'($urandom), 1'($urandom), 0, 0, 1);
    cyc(1, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 300; i++)
      cyc(1, 1'($urandom), 1'($urandom), $urandom_range(7) == 0, 1'($urandom), 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (38) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 1);
    repeat (20) cyc(1, 1, 1, 0, 0, 1);
    re = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) re = !re;
      cyc($urandom_range(299) != 0, 1'($urandom), 1'($urandom), $urandom_range(5) == 0, 1'($urandom), re);
    end
    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
